// File: rtl/qmca_clk_div_gen.sv
// Lock-sequenced clock-divider bank: holds a downstream reset until the DCM is
// locked and a hold-off has elapsed, then runs CHANNELS phase-aligned dividers.
module qmca_clk_div_gen #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLDOFF     = 3,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 LOCKED_IN,
  input  logic                 SYNC,
  input  logic [CHANNELS-1:0]  DIV_WE,
  input  logic [CNT_WIDTH-1:0] DIV_DATA,
  output logic [CHANNELS-1:0]  CLK_OUT,
  output logic [CHANNELS-1:0]  CE_OUT,
  output logic                 RST_OUT,
  output logic                 READY
);

  localparam int                   HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [CNT_WIDTH-1:0] DEF_RATIO = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] MIN_RATIO = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_HOLDOFF,
    ST_RUN
  } state_t;

  state_t               state;
  logic                 lk_meta;
  logic                 lk;
  logic [HW-1:0]        hold_cnt;
  logic                 run;
  logic                 enter;
  logic [CNT_WIDTH-1:0] wr_ratio;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= LOCKED_IN;
      lk      <= lk_meta;
    end
  end

  // Lock sequencer; RST_OUT and READY are registered alongside the state.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state    <= ST_WAIT_LOCK;
      hold_cnt <= '0;
      RST_OUT  <= 1'b1;
      READY    <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (lk) begin
            state    <= ST_HOLDOFF;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLDOFF: begin
          if (!lk) begin
            state <= ST_WAIT_LOCK;
          end else if (hold_cnt == '0) begin
            state   <= ST_RUN;
            RST_OUT <= 1'b0;
            READY   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_RUN: begin
          if (!lk) begin
            state   <= ST_WAIT_LOCK;
            RST_OUT <= 1'b1;
            READY   <= 1'b0;
          end
        end
        default: begin
          state   <= ST_WAIT_LOCK;
          RST_OUT <= 1'b1;
          READY   <= 1'b0;
        end
      endcase
    end
  end

  // Channels count only while RUN persists; the entry edge starts them in phase.
  assign run      = (state == ST_RUN) && lk;
  assign enter    = (state == ST_HOLDOFF) && lk && (hold_cnt == '0);
  assign wr_ratio = (DIV_DATA < MIN_RATIO) ? MIN_RATIO : DIV_DATA;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] active;
    logic [CNT_WIDTH-1:0] pending;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] half;
    logic                 wrap;
    logic                 clk_q;
    logic                 ce_q;

    // NOTE: assign every always_comb output on every path so no latch is inferred.
    always_comb begin
      half     = (active >> 1) + {{(CNT_WIDTH-1){1'b0}}, active[0]};
      wrap     = SYNC || (cnt == active - ONE);
      cnt_next = wrap ? '0 : cnt + ONE;
    end

    // NOTE: the ratio registers are reset too, so programmed ratios revert to
    // the default on BUS_RST instead of surviving it.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
        cnt     <= '0;
        active  <= DEF_RATIO;
        pending <= DEF_RATIO;
        clk_q   <= 1'b0;
        ce_q    <= 1'b0;
      end else begin
        if (DIV_WE[i]) begin
          pending <= wr_ratio;
        end
        if (run) begin
          cnt   <= cnt_next;
          ce_q  <= (cnt_next == '0);
          clk_q <= (cnt_next < half);
          // Old pending value is used, so a write on the wrap edge waits a period.
          if (cnt_next == '0) begin
            active <= pending;
          end
        end else begin
          cnt    <= '0;
          active <= pending;
          ce_q   <= enter;
          clk_q  <= enter;
        end
      end
    end

    assign CLK_OUT[i] = clk_q;
    assign CE_OUT[i]  = ce_q;
  end

endmodule

// File: tb/tb_qmca_clk_div_gen.sv
// Bench for qmca_clk_div_gen: cycle-level model compared every cycle plus
// directed lock, ratio, SYNC and reset scenarios with literal expectations.
module tb_qmca_clk_div_gen;

  localparam int CH   = 4;
  localparam int CW   = 8;
  localparam int HOLD = 3;
  localparam int DEF  = 4;

  logic          BUS_CLK   = 1'b0;
  logic          BUS_RST   = 1'b1;
  logic          LOCKED_IN = 1'b0;
  logic          SYNC      = 1'b0;
  logic [CH-1:0] DIV_WE    = '0;
  logic [CW-1:0] DIV_DATA  = '0;
  logic [CH-1:0] CLK_OUT;
  logic [CH-1:0] CE_OUT;
  logic          RST_OUT;
  logic          READY;

  int n_checks = 0;
  int n_fail   = 0;

  qmca_clk_div_gen #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (CW),
    .HOLDOFF    (HOLD),
    .DEFAULT_DIV(DEF)
  ) dut (
    .BUS_CLK  (BUS_CLK),
    .BUS_RST  (BUS_RST),
    .LOCKED_IN(LOCKED_IN),
    .SYNC     (SYNC),
    .DIV_WE   (DIV_WE),
    .DIV_DATA (DIV_DATA),
    .CLK_OUT  (CLK_OUT),
    .CE_OUT   (CE_OUT),
    .RST_OUT  (RST_OUT),
    .READY    (READY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: RUN holds once the synchronised lock has been seen high
  // for more than HOLDOFF consecutive edges; each channel tracks its position
  // inside the current period and the period length it started with.
  bit m_s1, m_s2, m_run;
  int m_streak;
  int m_pos  [CH];
  int m_per  [CH];
  int m_pend [CH];

  initial begin : model
    logic [CH-1:0] e_clk, e_ce;
    bit seen, run_now;
    forever begin
      @(posedge BUS_CLK);
      if (BUS_RST) begin
        m_s1 = 0; m_s2 = 0; m_run = 0; m_streak = 0;
        for (int c = 0; c < CH; c++) begin
          m_pos[c] = 0; m_per[c] = DEF; m_pend[c] = DEF;
        end
      end else begin
        seen     = m_s2;
        m_s2     = m_s1;
        m_s1     = LOCKED_IN;
        m_streak = seen ? m_streak + 1 : 0;
        run_now  = (m_streak > HOLD);
        for (int c = 0; c < CH; c++) begin
          if (run_now && !m_run) begin
            m_pos[c] = 0; m_per[c] = m_pend[c];
          end else if (run_now) begin
            if (SYNC || m_pos[c] + 1 == m_per[c]) begin
              m_pos[c] = 0; m_per[c] = m_pend[c];
            end else begin
              m_pos[c] = m_pos[c] + 1;
            end
          end else begin
            m_pos[c] = 0; m_per[c] = m_pend[c];
          end
          if (DIV_WE[c]) m_pend[c] = (int'(DIV_DATA) < 2) ? 2 : int'(DIV_DATA);
        end
        m_run = run_now;
      end
      #1;
      if (!BUS_RST) begin
        for (int c = 0; c < CH; c++) begin
          e_clk[c] = m_run && (m_pos[c] < (m_per[c] + 1) / 2);
          e_ce[c]  = m_run && (m_pos[c] == 0);
        end
        check("model_clk_out", 32'(CLK_OUT), 32'(e_clk));
        check("model_ce_out",  32'(CE_OUT),  32'(e_ce));
        check("model_rst_out", 32'(RST_OUT), 32'(!m_run));
        check("model_ready",   32'(READY),   32'(m_run));
      end
    end
  end

  task automatic wait_ce(input int ch);
    int k = 0;
    do begin
      @(negedge BUS_CLK);
      k++;
    end while (!CE_OUT[ch] && k < 100);
    check("ce_seen", 32'(CE_OUT[ch]), 32'd1);
  endtask

  task automatic measure(input int ch, output int per, output int high);
    wait_ce(ch);
    per  = 0;
    high = 0;
    do begin
      high += int'(CLK_OUT[ch]);
      per++;
      @(negedge BUS_CLK);
    end while (!CE_OUT[ch] && per < 300);
  endtask

  task automatic write_div(input int ch, input int val);
    DIV_WE     = '0;
    DIV_WE[ch] = 1'b1;
    DIV_DATA   = CW'(val);
    @(negedge BUS_CLK);
    DIV_WE = '0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [CH-1:0] exp_clk, exp_ce;
    bit c1_clk [10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 1};
    bit c1_ce  [10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int per, high, rw;
    int exp_per [CH] = '{3, 4, 5, 6};
    int exp_hi  [CH] = '{2, 2, 3, 3};

    // Reset values, then release on a falling edge; the next rising edge is edge 1.
    repeat (3) @(negedge BUS_CLK);
    check("reset_rst_out", 32'(RST_OUT), 32'd1);
    check("reset_ready",   32'(READY),   32'd0);
    check("reset_clk_out", 32'(CLK_OUT), 32'd0);
    check("reset_ce_out",  32'(CE_OUT),  32'd0);
    BUS_RST = 1'b0;

    // Lock first sampled at edge 10, so RUN starts at edge 15.
    repeat (9) @(negedge BUS_CLK);
    LOCKED_IN = 1'b1;
    for (int e = 10; e < 15; e++) begin
      @(negedge BUS_CLK);
      check("holdoff_rst_out", 32'(RST_OUT), 32'd1);
      check("holdoff_clk_out", 32'(CLK_OUT), 32'd0);
    end
    @(negedge BUS_CLK);
    check("entry_rst_out", 32'(RST_OUT), 32'd0);
    check("entry_ready",   32'(READY),   32'd1);
    check("entry_ce_out",  32'(CE_OUT),  32'hf);
    check("entry_clk_out", 32'(CLK_OUT), 32'hf);

    // Default 1,1,0,0 pattern; ratio 5 written to channel 1 on its wrap edge
    // (edge 23) only takes over at the following wrap (edge 27).
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge BUS_CLK);
      exp_clk = (k % 4 < 2) ? '1 : '0;
      exp_ce  = (k % 4 == 0) ? '1 : '0;
      if (k >= 8) begin
        exp_clk[1] = c1_clk[k-8];
        exp_ce[1]  = c1_ce[k-8];
      end
      check("div_clk_out", 32'(CLK_OUT), 32'(exp_clk));
      check("div_ce_out",  32'(CE_OUT),  32'(exp_ce));
      if (k == 7) begin
        DIV_WE   = 4'b0010;
        DIV_DATA = 8'd5;
      end
      if (k == 8) DIV_WE = '0;
    end

    // Last write wins: 0 then 7 inside one period of channel 2.
    wait_ce(2);
    DIV_WE   = 4'b0100;
    DIV_DATA = 8'd0;
    @(negedge BUS_CLK);
    DIV_DATA = 8'd7;
    @(negedge BUS_CLK);
    DIV_WE = '0;
    measure(2, per, high);
    check("last_wins_period", 32'(per),  32'd7);
    check("last_wins_high",   32'(high), 32'd4);

    // Ratio 1 clamps to 2.
    wait_ce(2);
    write_div(2, 1);
    measure(2, per, high);
    check("clamp_period", 32'(per),  32'd2);
    check("clamp_high",   32'(high), 32'd1);

    // Mixed ratios, then SYNC restarts every channel together.
    for (int c = 0; c < CH; c++) write_div(c, c + 3);
    rw = int'($urandom_range(20, 3));
    repeat (rw) @(negedge BUS_CLK);
    SYNC = 1'b1;
    @(negedge BUS_CLK);
    SYNC = 1'b0;
    check("sync_ce_out",  32'(CE_OUT),  32'hf);
    check("sync_clk_out", 32'(CLK_OUT), 32'hf);
    for (int c = 0; c < CH; c++) begin
      measure(c, per, high);
      check("sync_period", 32'(per),  32'(exp_per[c]));
      check("sync_high",   32'(high), 32'(exp_hi[c]));
    end

    // Lock loss: sampled low at edge m, outputs drop at edge m+2.
    LOCKED_IN = 1'b0;
    @(negedge BUS_CLK);
    check("loss_m_ready", 32'(READY), 32'd1);
    @(negedge BUS_CLK);
    check("loss_m1_rst_out", 32'(RST_OUT), 32'd0);
    @(negedge BUS_CLK);
    check("loss_rst_out", 32'(RST_OUT), 32'd1);
    check("loss_ready",   32'(READY),   32'd0);
    check("loss_clk_out", 32'(CLK_OUT), 32'd0);
    check("loss_ce_out",  32'(CE_OUT),  32'd0);

    // Relock with a one-cycle glitch during hold-off; RUN HOLD+2 edges after final rise.
    repeat (3) @(negedge BUS_CLK);
    LOCKED_IN = 1'b1;
    @(negedge BUS_CLK);
    @(negedge BUS_CLK);
    LOCKED_IN = 1'b0;
    @(negedge BUS_CLK);
    LOCKED_IN = 1'b1;
    for (int k = 0; k < HOLD + 2; k++) begin
      @(negedge BUS_CLK);
      check("glitch_rst_out", 32'(RST_OUT), 32'd1);
      check("glitch_ready",   32'(READY),   32'd0);
    end
    @(negedge BUS_CLK);
    check("relock_rst_out", 32'(RST_OUT), 32'd0);
    check("relock_ce_out",  32'(CE_OUT),  32'hf);
    check("relock_clk_out", 32'(CLK_OUT), 32'hf);

    // Asynchronous reset between edges.
    #2;
    BUS_RST = 1'b1;
    #1;
    check("async_rst_out", 32'(RST_OUT), 32'd1);
    check("async_ready",   32'(READY),   32'd0);
    check("async_clk_out", 32'(CLK_OUT), 32'd0);
    check("async_ce_out",  32'(CE_OUT),  32'd0);
    repeat (2) @(negedge BUS_CLK);
    BUS_RST = 1'b0;

    // Lock is already high: sampled at edge 1, RUN at edge 6, default ratios back.
    for (int e = 1; e < 6; e++) begin
      @(negedge BUS_CLK);
      check("rerun_rst_out", 32'(RST_OUT), 32'd1);
    end
    @(negedge BUS_CLK);
    check("rerun_entry_rst_out", 32'(RST_OUT), 32'd0);
    check("rerun_entry_ce_out",  32'(CE_OUT),  32'hf);
    for (int c = 0; c < CH; c++) begin
      measure(c, per, high);
      check("default_period", 32'(per),  32'(DEF));
      check("default_high",   32'(high), 32'(DEF / 2));
    end

    repeat (2) @(negedge BUS_CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qmca_clk_div_gen.md
# qmca_clk_div_gen

Parametrised, lock-sequenced clock-divider bank for the QMCA firmware. It runs on one fast clock, typically the buffered DCM output. It holds a downstream reset until the DCM reports lock and a programmable hold-off has elapsed. It then generates CHANNELS phase-aligned divided clocks and matching clock-enable strobes, each with a divide ratio that can be changed at runtime without glitches. It replaces the fixed FD/OR reset-delay chain and fixed DCM divide settings with one configurable block.

## Interface
- CHANNELS, 4: number of divider channels (1..16).
- CNT_WIDTH, 8: width of divide ratio and per-channel counter.
- HOLDOFF, 3: cycles spent in HOLDOFF after synchronised lock (>=1).
- DEFAULT_DIV, 4: divide ratio loaded into every channel on reset (>=2).
- BUS_CLK  in  1  block clock; all logic on rising edge.
- BUS_RST  in  1  asynchronous, active-high reset.
- LOCKED_IN  in  1  DCM lock, asynchronous to BUS_CLK; 2-FF synchronised internally.
- SYNC  in  1  synchronous; restarts all channel counters in phase.
- DIV_WE  in  CHANNELS  per-channel write strobe for DIV_DATA.
- DIV_DATA  in  CNT_WIDTH  new divide ratio, shared by all channels.
- CLK_OUT  out  CHANNELS  divided clocks, registered.
- CE_OUT  out  CHANNELS  one-cycle strobe coincident with each CLK_OUT rising period start.
- RST_OUT  out  1  downstream reset, active-high.
- READY  out  1  high in RUN.

## Operation
- Reset values: FSM=WAIT_LOCK, synchroniser=0, RST_OUT=1, READY=0, CLK_OUT=0, CE_OUT=0, counters=0, active and pending ratios=DEFAULT_DIV.
- FSM states:
  - WAIT_LOCK: go to HOLDOFF when synchronised lock (lk) is 1; load the hold-off counter with HOLDOFF-1.
  - HOLDOFF: decrement each cycle. lk=0 returns to WAIT_LOCK. At count 0 with lk=1, go to RUN.
  - RUN: stay while lk=1. lk=0 returns to WAIT_LOCK.
- Outside RUN: RST_OUT=1, READY=0, CLK_OUT=0, CE_OUT=0, counters held at 0, pending ratio copied to active every cycle.
- RUN entry edge, in a single edge: RST_OUT<=0, READY<=1, every counter<=0, every CE_OUT<=1, every CLK_OUT<=1.
- Per channel in RUN, with active ratio D and H=ceil(D/2):
  - c_next = 0 if SYNC or c==D-1, else c+1.
  - c<=c_next; CE_OUT<=(c_next==0); CLK_OUT<=(c_next<H).
  - Result: period D cycles, high H cycles; odd D is high one cycle longer than low.
- Ratio writes:
  - DIV_WE[i]=1 stores DIV_DATA into pending[i].
  - Values 0 and 1 are clamped to 2.
  - Multiple writes before application: last write wins.
- Ratio application: pending becomes active on the edge where c_next==0 (wrap or SYNC). A period already in progress always completes with the old ratio.
- Simultaneous DIV_WE and wrap on the same edge: the new value is stored as pending and applies at the following wrap, not the current one.
- SYNC: in RUN, all channels restart together (CE_OUT=1 on all channels the next cycle) and adopt pending ratios. Ignored outside RUN.
- BUS_RST mid-operation: all outputs take reset values immediately (asynchronous). Programmed ratios are lost and revert to DEFAULT_DIV.

## Timing
- Lock rise: LOCKED_IN first sampled high at edge n -> lk high after n+1 -> HOLDOFF entered at n+2 -> RUN entered at n+2+HOLDOFF. RST_OUT falls and first CE_OUT appears at that edge.
- Lock loss: LOCKED_IN first sampled low at edge m -> at edge m+2: RST_OUT=1, READY=0, all CLK_OUT/CE_OUT=0.
- A lock glitch shorter than the synchroniser resolution is not filtered. Any lk=0 during HOLDOFF restarts the full hold-off.
- SYNC sampled at edge s -> CE_OUT=1 on all channels after edge s, i.e. 1-cycle latency.
- DIV_WE at edge w -> pending valid after w. Takes effect at the first edge after w with c_next==0.
- All channels with equal ratios are cycle-aligned at all times in RUN.

## Test plan
- Reset release, then LOCKED_IN high before edge 10, HOLDOFF=3 -> RST_OUT falls and CE_OUT=4'b1111 exactly after edge 15. RST_OUT=1 and CLK_OUT=0 before that.
- DEFAULT_DIV=4 in RUN -> each CLK_OUT has pattern 1,1,0,0 and CE_OUT pulses every 4 cycles. Write DIV_DATA=5 to channel 1 -> after current period, channel 1 has pattern 1,1,1,0,0, while other channels are unchanged.
- Write 0 to channel 2, then 7 to channel 2 before its wrap -> channel 2 adopts 7 (last wins). A separate write of 1 to channel 2 -> period 2.
- Program channels to 3, 4, 5, 6, wait random cycles, pulse SYNC -> next cycle CE_OUT=4'b1111 and CLK_OUT=4'b1111; periods unchanged afterwards.
- Drop LOCKED_IN in RUN -> two edges later RST_OUT=1 and outputs 0. Re-raise it, then drop it for 1 cycle during HOLDOFF -> hold-off restarts, and RUN is entered HOLDOFF+2 edges after the final rise.
- Assert BUS_RST asynchronously mid-period in RUN -> outputs reset without waiting for a clock edge. After release and relock, all channels run at DEFAULT_DIV.
